// File: rtl/sdtw_stream_engine.sv
// sdtw_stream_engine: subsequence-DTW scoring engine on an AXI-Stream link.
// A reference packet (tuser=1 on its first beat) is stored on chip. Each query
// packet is scored against every sub-span of that reference, one DTW row per
// query sample and one cell per cycle. The best score, and optionally its end
// position, is streamed out after the last query sample.
// Optional feature macro: SDTW_POS_OUT_EN. When defined, a second result beat
// carries the end position; when undefined, only the score beat is sent.
module sdtw_stream_engine #(
  parameter int DATA_WIDTH      = 16,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int SCORE_WIDTH     = 32,
  parameter int REF_DEPTH       = 256,
  parameter int IDX_WIDTH       = $clog2(REF_DEPTH)
) (
  input  logic                       i_axis_clk,
  input  logic                       i_axis_rst,
  input  logic                       i_axis_in_tuser,
  input  logic                       i_axis_in_tvalid,
  output logic                       o_axis_in_tready,
  input  logic                       i_axis_in_tlast,
  input  logic [AXIS_DATA_WIDTH-1:0] i_axis_in_tdata,
  output logic                       o_axis_out_tvalid,
  input  logic                       i_axis_out_tready,
  output logic                       o_axis_out_tlast,
  output logic [AXIS_DATA_WIDTH-1:0] o_axis_out_tdata,
  output logic [IDX_WIDTH:0]         o_ref_len,
  output logic                       o_ref_ovf,
  output logic                       o_busy
);

  typedef enum logic [2:0] {
    IDLE, LOAD_REF, ROW, EMIT_SCORE
`ifdef SDTW_POS_OUT_EN
    , EMIT_POS
`endif
  } state_t;

  localparam logic [IDX_WIDTH:0] DEPTH_L = (IDX_WIDTH+1)'(REF_DEPTH);

  state_t                     state_reg;
  logic                       in_ready_reg;
  logic                       out_valid_reg;
  logic                       out_last_reg;
  logic [AXIS_DATA_WIDTH-1:0] out_data_reg;
  logic [IDX_WIDTH:0]         ref_len_reg;
  logic                       ref_ovf_reg;
  logic                       query_mid_reg;   // inside a query packet (first beat seen)
  logic                       first_row_reg;   // current row is the free-start row
  logic                       last_row_reg;    // current row's sample carried tlast
  logic [DATA_WIDTH-1:0]      q_reg;
  logic [IDX_WIDTH-1:0]       j_reg;
  logic [SCORE_WIDTH-1:0]     d_left_reg;      // D[j-1] of the current row
  logic [SCORE_WIDTH-1:0]     dprev_diag_reg;  // Dprev[j-1] of the previous row
  logic [SCORE_WIDTH-1:0]     best_reg;
`ifdef SDTW_POS_OUT_EN
  logic [IDX_WIDTH-1:0]       pos_reg;
  logic [AXIS_DATA_WIDTH-1:0] pos_data_reg;
  logic [IDX_WIDTH-1:0]       pos_next;
`endif

  // Reference samples and the previous DTW row, both with registered reads.
  logic [DATA_WIDTH-1:0]  ref_mem [REF_DEPTH];
  logic [SCORE_WIDTH-1:0] row_mem [REF_DEPTH];
  logic [DATA_WIDTH-1:0]  ref_rd_reg;
  logic [SCORE_WIDTH-1:0] row_rd_reg;

  logic                       in_fire;
  logic                       out_fire;
  logic                       ref_we;
  logic [IDX_WIDTH-1:0]       ref_waddr;
  logic [IDX_WIDTH-1:0]       rd_addr;
  logic signed [DATA_WIDTH:0] diff;
  logic [DATA_WIDTH:0]        mag;
  logic [SCORE_WIDTH-1:0]     d_local;
  logic [SCORE_WIDTH-1:0]     min3;
  logic [SCORE_WIDTH-1:0]     d_cell;
  logic [SCORE_WIDTH-1:0]     best_next;
  logic                       better;
  logic                       row_last_cell;
  logic                       unused_in_bits;

  assign unused_in_bits    = ^i_axis_in_tdata;
  assign in_fire           = in_ready_reg && i_axis_in_tvalid;
  assign out_fire          = out_valid_reg && i_axis_out_tready;
  assign o_axis_in_tready  = in_ready_reg;
  assign o_axis_out_tvalid = out_valid_reg;
  assign o_axis_out_tlast  = out_last_reg;
  assign o_axis_out_tdata  = out_data_reg;
  assign o_ref_len         = ref_len_reg;
  assign o_ref_ovf         = ref_ovf_reg;
  assign o_busy            = (state_reg != IDLE);

  function automatic logic [SCORE_WIDTH-1:0] sat_add(input logic [SCORE_WIDTH-1:0] a,
                                                     input logic [SCORE_WIDTH-1:0] b);
    logic [SCORE_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SCORE_WIDTH] ? '1 : s[SCORE_WIDTH-1:0];
  endfunction

  // Reference writes and read-ahead address; the read runs one cell ahead of the compute.
  always_comb begin
    ref_we    = 1'b0;
    ref_waddr = ref_len_reg[IDX_WIDTH-1:0];
    if (in_fire && state_reg == IDLE && !query_mid_reg && i_axis_in_tuser) begin
      ref_we    = 1'b1;
      ref_waddr = '0;
    end else if (in_fire && state_reg == LOAD_REF && ref_len_reg < DEPTH_L) begin
      ref_we = 1'b1;
    end
    rd_addr = (state_reg == ROW) ? IDX_WIDTH'(j_reg + 1'b1) : '0;
  end

  // Reference memory: one write port, one registered read port.
  always_ff @(posedge i_axis_clk) begin
    if (ref_we) ref_mem[ref_waddr] <= i_axis_in_tdata[DATA_WIDTH-1:0];
    ref_rd_reg <= ref_mem[rd_addr];
  end

  // Row buffer: write cell j while reading Dprev[j+1] for the next cell.
  always_ff @(posedge i_axis_clk) begin
    if (state_reg == ROW) row_mem[j_reg] <= d_cell;
    row_rd_reg <= row_mem[rd_addr];
  end

  // Absolute difference at DATA_WIDTH+1 bits; the extra bit makes it exact.
  always_comb begin
    diff = $signed({q_reg[DATA_WIDTH-1], q_reg}) - $signed({ref_rd_reg[DATA_WIDTH-1], ref_rd_reg});
    mag  = diff[DATA_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
  end

  generate
    if (SCORE_WIDTH >= DATA_WIDTH + 1) begin : g_dist_ext
      // Distance always fits the score width.
      always_comb d_local = SCORE_WIDTH'(mag);
    end else begin : g_dist_sat
      // Narrow score: clamp distances that do not fit.
      always_comb d_local = (|mag[DATA_WIDTH:SCORE_WIDTH]) ? '1 : mag[SCORE_WIDTH-1:0];
    end
  endgenerate

  // DTW cell recurrence plus running minimum for the final row.
  always_comb begin
    min3 = row_rd_reg;
    if (d_left_reg < min3)     min3 = d_left_reg;
    if (dprev_diag_reg < min3) min3 = dprev_diag_reg;
    if (first_row_reg)         d_cell = d_local;
    else if (j_reg == '0)      d_cell = sat_add(row_rd_reg, d_local);
    else                       d_cell = sat_add(d_local, min3);
    better        = (j_reg == '0) || (d_cell < best_reg);
    best_next     = better ? d_cell : best_reg;
    row_last_cell = ({1'b0, j_reg} == ref_len_reg - 1'b1);
`ifdef SDTW_POS_OUT_EN
    pos_next = better ? j_reg : pos_reg;
`endif
  end

  // Control FSM with registered stream outputs.
  always_ff @(posedge i_axis_clk or negedge i_axis_rst) begin
    if (!i_axis_rst) begin
      state_reg      <= IDLE;
      in_ready_reg   <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      out_data_reg   <= '0;
      ref_len_reg    <= '0;
      ref_ovf_reg    <= 1'b0;
      query_mid_reg  <= 1'b0;
      first_row_reg  <= 1'b0;
      last_row_reg   <= 1'b0;
      q_reg          <= '0;
      j_reg          <= '0;
      d_left_reg     <= '0;
      dprev_diag_reg <= '0;
      best_reg       <= '0;
`ifdef SDTW_POS_OUT_EN
      pos_reg        <= '0;
      pos_data_reg   <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          in_ready_reg <= 1'b1;
          if (in_fire) begin
            if (!query_mid_reg && i_axis_in_tuser) begin
              ref_len_reg <= (IDX_WIDTH+1)'(1);
              ref_ovf_reg <= 1'b0;
              if (!i_axis_in_tlast) state_reg <= LOAD_REF;
            end else begin
              q_reg         <= i_axis_in_tdata[DATA_WIDTH-1:0];
              first_row_reg <= !query_mid_reg;
              last_row_reg  <= i_axis_in_tlast;
              query_mid_reg <= !i_axis_in_tlast;
              if (ref_len_reg != '0) begin
                state_reg    <= ROW;
                in_ready_reg <= 1'b0;
                j_reg        <= '0;
              end else if (i_axis_in_tlast) begin
                state_reg     <= EMIT_SCORE;
                in_ready_reg  <= 1'b0;
                out_valid_reg <= 1'b1;
                out_data_reg  <= '1;
`ifdef SDTW_POS_OUT_EN
                out_last_reg  <= 1'b0;
                pos_data_reg  <= '1;
`else
                out_last_reg  <= 1'b1;
`endif
              end
            end
          end
        end
        LOAD_REF: begin
          if (in_fire) begin
            if (ref_len_reg < DEPTH_L) ref_len_reg <= ref_len_reg + 1'b1;
            else                       ref_ovf_reg <= 1'b1;
            if (i_axis_in_tlast) state_reg <= IDLE;
          end
        end
        ROW: begin
          d_left_reg     <= d_cell;
          dprev_diag_reg <= row_rd_reg;
          best_reg       <= best_next;
`ifdef SDTW_POS_OUT_EN
          pos_reg        <= pos_next;
`endif
          j_reg          <= IDX_WIDTH'(j_reg + 1'b1);
          if (row_last_cell) begin
            if (last_row_reg) begin
              state_reg     <= EMIT_SCORE;
              out_valid_reg <= 1'b1;
              out_data_reg  <= AXIS_DATA_WIDTH'(best_next);
`ifdef SDTW_POS_OUT_EN
              out_last_reg  <= 1'b0;
              pos_data_reg  <= AXIS_DATA_WIDTH'(pos_next);
`else
              out_last_reg  <= 1'b1;
`endif
            end else begin
              state_reg    <= IDLE;
              in_ready_reg <= 1'b1;
            end
          end
        end
        EMIT_SCORE: begin
          if (out_fire) begin
`ifdef SDTW_POS_OUT_EN
            state_reg    <= EMIT_POS;
            out_data_reg <= pos_data_reg;
            out_last_reg <= 1'b1;
`else
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            in_ready_reg  <= 1'b1;
`endif
          end
        end
`ifdef SDTW_POS_OUT_EN
        EMIT_POS: begin
          if (out_fire) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
